// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: the decoded control bundle carried from ID
// into EX, plus the constants used for bubbles and the hard-wired zero register.
package pipeline_pkg;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_to_reg;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       jump;
        logic [2:0] funct3;
    } idex_ctrl_t;

    localparam logic [4:0] REG_ZERO      = 5'd0;
    localparam idex_ctrl_t IDEX_CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_register_if.sv
// ID/EX bus: decode-side operands, writeback bypass, flush/hold controls and
// the registered EX-side fields. The slave side is the pipeline register itself.
interface id_ex_register_if
    import pipeline_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic             i_id_valid;
    logic [XLEN-1:0]  i_id_pc;
    logic [4:0]       i_id_rs1;
    logic [4:0]       i_id_rs2;
    logic [4:0]       i_id_rd;
    logic             i_id_uses_rs1;
    logic             i_id_uses_rs2;
    logic [XLEN-1:0]  i_id_rs1_value;
    logic [XLEN-1:0]  i_id_rs2_value;
    logic [XLEN-1:0]  i_id_imm;
    idex_ctrl_t       i_id_ctrl;
    logic             i_wb_reg_write;
    logic [4:0]       i_wb_rd;
    logic [XLEN-1:0]  i_wb_value;
    logic             i_flush;
    logic             i_hold;

    logic             o_idex_valid;
    logic [XLEN-1:0]  o_idex_pc;
    logic [XLEN-1:0]  o_idex_imm;
    logic [4:0]       o_idex_rs1;
    logic [4:0]       o_idex_rs2;
    logic [4:0]       o_idex_rd;
    logic [XLEN-1:0]  o_idex_rs1_value;
    logic [XLEN-1:0]  o_idex_rs2_value;
    idex_ctrl_t       o_idex_ctrl;
    logic             o_stall;
    logic [CNT_W-1:0] o_stall_count;

    modport slave (
        input  i_id_valid, i_id_pc, i_id_rs1, i_id_rs2, i_id_rd,
               i_id_uses_rs1, i_id_uses_rs2, i_id_rs1_value, i_id_rs2_value,
               i_id_imm, i_id_ctrl, i_wb_reg_write, i_wb_rd, i_wb_value,
               i_flush, i_hold,
        output o_idex_valid, o_idex_pc, o_idex_imm, o_idex_rs1, o_idex_rs2,
               o_idex_rd, o_idex_rs1_value, o_idex_rs2_value, o_idex_ctrl,
               o_stall, o_stall_count
    );

    modport master (
        output i_id_valid, i_id_pc, i_id_rs1, i_id_rs2, i_id_rd,
               i_id_uses_rs1, i_id_uses_rs2, i_id_rs1_value, i_id_rs2_value,
               i_id_imm, i_id_ctrl, i_wb_reg_write, i_wb_rd, i_wb_value,
               i_flush, i_hold,
        input  o_idex_valid, o_idex_pc, o_idex_imm, o_idex_rs1, o_idex_rs2,
               o_idex_rd, o_idex_rs1_value, o_idex_rs2_value, o_idex_ctrl,
               o_stall, o_stall_count
    );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check: a load sitting in EX whose destination
// is read by the real instruction in ID. Writes to x0 never create a hazard.
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic       i_idex_valid,
    input  logic       i_idex_mem_to_reg,
    input  logic [4:0] i_idex_rd,
    input  logic       i_id_valid,
    input  logic       i_id_uses_rs1,
    input  logic [4:0] i_id_rs1,
    input  logic       i_id_uses_rs2,
    input  logic [4:0] i_id_rs2,
    output logic       o_lu
);

    // Hazard when either used source matches a nonzero load destination
    always_comb begin
        o_lu = i_idex_valid & i_idex_mem_to_reg & i_id_valid
             & (i_idex_rd != REG_ZERO)
             & ((i_id_uses_rs1 & (i_id_rs1 == i_idex_rd))
              | (i_id_uses_rs2 & (i_id_rs2 == i_idex_rd)));
    end

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// downstream hold, same-cycle writeback bypass and a saturating bubble counter.
module id_ex_register
    import pipeline_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
)(
    input  logic               i_clk,
    input  logic               i_rst,
    id_ex_register_if.slave    bus
);

    logic             valid_q,     valid_d;
    logic [XLEN-1:0]  pc_q,        pc_d;
    logic [XLEN-1:0]  imm_q,       imm_d;
    logic [4:0]       rs1_q,       rs1_d;
    logic [4:0]       rs2_q,       rs2_d;
    logic [4:0]       rd_q,        rd_d;
    logic [XLEN-1:0]  rs1_value_q, rs1_value_d;
    logic [XLEN-1:0]  rs2_value_q, rs2_value_d;
    idex_ctrl_t       ctrl_q,      ctrl_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic             lu;
    logic [XLEN-1:0]  rs1_value_in;
    logic [XLEN-1:0]  rs2_value_in;

    load_use_detect u_load_use_detect (
        .i_idex_valid      (valid_q),
        .i_idex_mem_to_reg (ctrl_q.mem_to_reg),
        .i_idex_rd         (rd_q),
        .i_id_valid        (bus.i_id_valid),
        .i_id_uses_rs1     (bus.i_id_uses_rs1),
        .i_id_rs1          (bus.i_id_rs1),
        .i_id_uses_rs2     (bus.i_id_uses_rs2),
        .i_id_rs2          (bus.i_id_rs2),
        .o_lu              (lu)
    );

    // Operand capture: writeback data overrides the register file; x0 reads as zero
    always_comb begin
        rs1_value_in = bus.i_id_rs1_value;
        rs2_value_in = bus.i_id_rs2_value;
        if (bus.i_wb_reg_write && (bus.i_wb_rd != REG_ZERO) && (bus.i_wb_rd == bus.i_id_rs1)) begin
            rs1_value_in = bus.i_wb_value;
        end
        if (bus.i_wb_reg_write && (bus.i_wb_rd != REG_ZERO) && (bus.i_wb_rd == bus.i_id_rs2)) begin
            rs2_value_in = bus.i_wb_value;
        end
        if (bus.i_id_rs1 == REG_ZERO) begin
            rs1_value_in = '0;
        end
        if (bus.i_id_rs2 == REG_ZERO) begin
            rs2_value_in = '0;
        end
    end

    // Next-state selection: flush beats hold beats load-use bubble beats load
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        imm_d       = imm_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        rs1_value_d = rs1_value_q;
        rs2_value_d = rs2_value_q;
        ctrl_d      = ctrl_q;
        cnt_d       = cnt_q;
        if (bus.i_flush || (!bus.i_hold && lu)) begin
            // Bubbles are fully zeroed so EX never sees stale operands
            valid_d     = 1'b0;
            pc_d        = '0;
            imm_d       = '0;
            rs1_d       = REG_ZERO;
            rs2_d       = REG_ZERO;
            rd_d        = REG_ZERO;
            rs1_value_d = '0;
            rs2_value_d = '0;
            ctrl_d      = IDEX_CTRL_NOP;
            if (!bus.i_flush && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (!bus.i_hold) begin
            valid_d     = bus.i_id_valid;
            pc_d        = bus.i_id_pc;
            imm_d       = bus.i_id_imm;
            rs1_d       = bus.i_id_rs1;
            rs2_d       = bus.i_id_rs2;
            rd_d        = bus.i_id_valid ? bus.i_id_rd : REG_ZERO;
            rs1_value_d = rs1_value_in;
            rs2_value_d = rs2_value_in;
            ctrl_d      = bus.i_id_valid ? bus.i_id_ctrl : IDEX_CTRL_NOP;
        end
    end

    // Pipeline register state with asynchronous clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            imm_q       <= '0;
            rs1_q       <= REG_ZERO;
            rs2_q       <= REG_ZERO;
            rd_q        <= REG_ZERO;
            rs1_value_q <= '0;
            rs2_value_q <= '0;
            ctrl_q      <= IDEX_CTRL_NOP;
            cnt_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            rs1_value_q <= rs1_value_d;
            rs2_value_q <= rs2_value_d;
            ctrl_q      <= ctrl_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.o_stall          = (lu | bus.i_hold) & ~bus.i_flush;
    assign bus.o_idex_valid     = valid_q;
    assign bus.o_idex_pc        = pc_q;
    assign bus.o_idex_imm       = imm_q;
    assign bus.o_idex_rs1       = rs1_q;
    assign bus.o_idex_rs2       = rs2_q;
    assign bus.o_idex_rd        = rd_q;
    assign bus.o_idex_rs1_value = rs1_value_q;
    assign bus.o_idex_rs2_value = rs2_value_q;
    assign bus.o_idex_ctrl      = ctrl_q;
    assign bus.o_stall_count    = cnt_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Directed bench for id_ex_register: a vector table for the single-cycle
// behaviours plus hand sequences for async reset and counter saturation.
module tb_id_ex_register;
    import pipeline_pkg::*;

    typedef enum logic [1:0] {K_LOAD, K_BUB, K_HOLD} kind_e;

    typedef struct {
        logic        id_valid;
        logic [63:0] pc;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic [63:0] v1;
        logic [63:0] v2;
        idex_ctrl_t  ctrl;
        logic        wbwe;
        logic [4:0]  wbrd;
        logic [63:0] wbval;
        logic        flush;
        logic        hold;
        logic        exp_stall;
        kind_e       kind;
        logic [63:0] e_v1;
        logic [63:0] e_v2;
        logic [31:0] e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    id_ex_register_if #(.XLEN(64), .CNT_W(32)) bus ();
    id_ex_register    #(.XLEN(64), .CNT_W(32)) dut  (.i_clk(clk), .i_rst(rst), .bus(bus));
    id_ex_register_if #(.XLEN(64), .CNT_W(2))  bus2 ();
    id_ex_register    #(.XLEN(64), .CNT_W(2))  dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

    // expected EX-side contents
    logic        m_valid;
    logic [63:0] m_pc, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    idex_ctrl_t  m_ctrl;

    idex_ctrl_t  c_add, c_ld;
    vec_t        vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic idex_ctrl_t mkc(input logic [3:0] op, input logic src, input logic m2r,
                                       input logic rw, input logic [2:0] f3);
        idex_ctrl_t c;
        c = '0;
        c.alu_op = op; c.alu_src = src; c.mem_to_reg = m2r; c.reg_write = rw; c.funct3 = f3;
        return c;
    endfunction

    function automatic vec_t mk(input logic idv, input logic [63:0] pc,
                                input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rd, input logic [63:0] v1, input logic [63:0] v2,
                                input idex_ctrl_t ctrl, input logic wbwe, input logic [4:0] wbrd,
                                input logic [63:0] wbval, input logic flush, input logic hold,
                                input logic es, input kind_e kind, input logic [63:0] ev1,
                                input logic [63:0] ev2, input logic [31:0] ecnt);
        vec_t v;
        v.id_valid = idv; v.pc = pc; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd;
        v.v1 = v1; v.v2 = v2; v.ctrl = ctrl; v.wbwe = wbwe; v.wbrd = wbrd; v.wbval = wbval;
        v.flush = flush; v.hold = hold; v.exp_stall = es; v.kind = kind;
        v.e_v1 = ev1; v.e_v2 = ev2; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.i_id_valid     = v.id_valid;
        bus.i_id_pc        = v.pc;
        bus.i_id_imm       = 64'hFFFF_0000_0000_0000 | v.pc;
        bus.i_id_rs1       = v.rs1;
        bus.i_id_rs2       = v.rs2;
        bus.i_id_rd        = v.rd;
        bus.i_id_uses_rs1  = v.u1;
        bus.i_id_uses_rs2  = v.u2;
        bus.i_id_rs1_value = v.v1;
        bus.i_id_rs2_value = v.v2;
        bus.i_id_ctrl      = v.ctrl;
        bus.i_wb_reg_write = v.wbwe;
        bus.i_wb_rd        = v.wbrd;
        bus.i_wb_value     = v.wbval;
        bus.i_flush        = v.flush;
        bus.i_hold         = v.hold;
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        chk({tag, " stall"}, 64'(bus.o_stall), 64'(v.exp_stall));
        @(posedge clk);
        #1;
        case (v.kind)
            K_LOAD: begin
                m_valid = v.id_valid;
                m_pc    = v.pc;
                m_imm   = 64'hFFFF_0000_0000_0000 | v.pc;
                m_rs1   = v.rs1;
                m_rs2   = v.rs2;
                m_rd    = v.id_valid ? v.rd : 5'd0;
                m_ctrl  = v.id_valid ? v.ctrl : IDEX_CTRL_NOP;
            end
            K_BUB: begin
                m_valid = 1'b0; m_pc = '0; m_imm = '0;
                m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = IDEX_CTRL_NOP;
            end
            default: ;
        endcase
        chk({tag, " valid"}, 64'(bus.o_idex_valid), 64'(m_valid));
        chk({tag, " pc"},    bus.o_idex_pc, m_pc);
        chk({tag, " imm"},   bus.o_idex_imm, m_imm);
        chk({tag, " rs1"},   64'(bus.o_idex_rs1), 64'(m_rs1));
        chk({tag, " rs2"},   64'(bus.o_idex_rs2), 64'(m_rs2));
        chk({tag, " rd"},    64'(bus.o_idex_rd), 64'(m_rd));
        chk({tag, " ctrl"},  64'(bus.o_idex_ctrl), 64'(m_ctrl));
        chk({tag, " rs1v"},  bus.o_idex_rs1_value, v.e_v1);
        chk({tag, " rs2v"},  bus.o_idex_rs2_value, v.e_v2);
        chk({tag, " cnt"},   64'(bus.o_stall_count), 64'(v.e_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        c_add = mkc(4'h0, 1'b0, 1'b0, 1'b1, 3'b000);
        c_ld  = mkc(4'h0, 1'b1, 1'b1, 1'b1, 3'b011);

        //            idv pc      rs1 u1 rs2 u2 rd  v1      v2     ctrl  we rd val      fl ho st kind    ev1      ev2      cnt
        vecs.push_back(mk(1, 'h100, 1, 1, 2, 1, 3,  5,      7,     c_add, 0, 0, 0,       0, 0, 0, K_LOAD, 5,       7,       0));
        vecs.push_back(mk(1, 'h104, 1, 1, 0, 0, 5,  'h20,   'h99,  c_ld,  0, 0, 0,       0, 0, 0, K_LOAD, 'h20,    0,       0));
        vecs.push_back(mk(1, 'h108, 5, 1, 2, 1, 6,  'h11,   'h22,  c_add, 0, 0, 0,       0, 0, 1, K_BUB,  0,       0,       1));
        vecs.push_back(mk(1, 'h108, 5, 1, 2, 1, 6,  'h11,   'h22,  c_add, 0, 0, 0,       0, 0, 0, K_LOAD, 'h11,    'h22,    1));
        vecs.push_back(mk(1, 'h10C, 1, 1, 0, 0, 0,  3,      'h77,  c_ld,  0, 0, 0,       0, 0, 0, K_LOAD, 3,       0,       1));
        vecs.push_back(mk(1, 'h110, 0, 1, 0, 1, 8,  'h55,   'h66,  c_add, 0, 0, 0,       0, 0, 0, K_LOAD, 0,       0,       1));
        vecs.push_back(mk(1, 'h114, 3, 1, 7, 1, 9,  4,      1,     c_add, 1, 7, 'hDEAD,  0, 0, 0, K_LOAD, 4,       'hDEAD,  1));
        vecs.push_back(mk(1, 'h118, 3, 1, 4, 1, 10, 'h31,   'h41,  c_add, 0, 3, 'hBEEF,  0, 0, 0, K_LOAD, 'h31,    'h41,    1));
        vecs.push_back(mk(1, 'h11C, 4, 1, 4, 1, 11, 1,      2,     c_add, 1, 4, 'hCAFE,  0, 0, 0, K_LOAD, 'hCAFE,  'hCAFE,  1));
        vecs.push_back(mk(1, 'h120, 0, 1, 0, 1, 12, 5,      6,     c_add, 1, 0, 'hBAD,   0, 0, 0, K_LOAD, 0,       0,       1));
        vecs.push_back(mk(0, 'h124, 1, 1, 2, 1, 12, 7,      8,     c_add, 0, 0, 0,       0, 0, 0, K_LOAD, 7,       8,       1));
        vecs.push_back(mk(1, 'h128, 1, 1, 0, 0, 5,  1,      0,     c_ld,  0, 0, 0,       0, 0, 0, K_LOAD, 1,       0,       1));
        vecs.push_back(mk(0, 'h12C, 5, 1, 5, 1, 13, 3,      4,     c_add, 0, 0, 0,       0, 0, 0, K_LOAD, 3,       4,       1));
        vecs.push_back(mk(1, 'h130, 1, 1, 0, 0, 5,  2,      0,     c_ld,  0, 0, 0,       0, 0, 0, K_LOAD, 2,       0,       1));
        vecs.push_back(mk(1, 'h134, 2, 1, 5, 1, 14, 8,      9,     c_add, 0, 0, 0,       1, 0, 0, K_BUB,  0,       0,       1));
        vecs.push_back(mk(1, 'h138, 2, 1, 3, 1, 15, 'hA,    'hB,   c_add, 0, 0, 0,       0, 0, 0, K_LOAD, 'hA,     'hB,     1));
        vecs.push_back(mk(1, 'h13C, 6, 1, 7, 1, 16, 'hC,    'hD,   c_add, 0, 0, 0,       0, 1, 1, K_HOLD, 'hA,     'hB,     1));
        vecs.push_back(mk(1, 'h140, 6, 1, 7, 1, 16, 'hC,    'hD,   c_add, 1, 6, 'h77,    0, 1, 1, K_HOLD, 'hA,     'hB,     1));
        vecs.push_back(mk(1, 'h144, 6, 1, 7, 1, 16, 'hC,    'hD,   c_ld,  0, 0, 0,       0, 1, 1, K_HOLD, 'hA,     'hB,     1));
        vecs.push_back(mk(1, 'h150, 1, 1, 0, 0, 7,  3,      0,     c_ld,  0, 0, 0,       0, 0, 0, K_LOAD, 3,       0,       1));
        vecs.push_back(mk(1, 'h154, 7, 1, 0, 0, 17, 1,      2,     c_add, 0, 0, 0,       0, 1, 1, K_HOLD, 3,       0,       1));
        vecs.push_back(mk(1, 'h154, 7, 1, 0, 0, 17, 1,      2,     c_add, 0, 0, 0,       0, 0, 1, K_BUB,  0,       0,       2));
        vecs.push_back(mk(1, 'h154, 7, 1, 0, 0, 17, 1,      2,     c_add, 0, 0, 0,       0, 0, 0, K_LOAD, 1,       0,       2));
        vecs.push_back(mk(1, 'h158, 1, 1, 2, 1, 18, 5,      6,     c_add, 0, 0, 0,       1, 1, 0, K_BUB,  0,       0,       2));
        vecs.push_back(mk(1, 'h15C, 1, 1, 0, 0, 9,  4,      0,     c_ld,  0, 0, 0,       0, 0, 0, K_LOAD, 4,       0,       2));
        vecs.push_back(mk(1, 'h160, 1, 1, 9, 0, 19, 5,      6,     c_add, 0, 0, 0,       0, 0, 0, K_LOAD, 5,       6,       2));
        vecs.push_back(mk(1, 'h164, 1, 1, 0, 0, 9,  4,      0,     c_ld,  0, 0, 0,       0, 0, 0, K_LOAD, 4,       0,       2));
        vecs.push_back(mk(1, 'h168, 1, 1, 9, 1, 20, 5,      6,     c_add, 0, 0, 0,       0, 0, 1, K_BUB,  0,       0,       3));
        vecs.push_back(mk(1, 'h200, 1, 1, 2, 1, 5,  'h10,   'h20,  c_ld,  0, 0, 0,       0, 0, 0, K_LOAD, 'h10,    'h20,    3));

        // reset state
        m_valid = 1'b0; m_pc = '0; m_imm = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = IDEX_CTRL_NOP;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDEX_CTRL_NOP, 0, 0, 0, 0, 0, 0, K_LOAD, 0, 0, 0));
        bus2.i_id_valid = 0; bus2.i_id_pc = '0; bus2.i_id_imm = '0; bus2.i_id_rs1 = '0;
        bus2.i_id_rs2 = '0; bus2.i_id_rd = '0; bus2.i_id_uses_rs1 = 0; bus2.i_id_uses_rs2 = 0;
        bus2.i_id_rs1_value = '0; bus2.i_id_rs2_value = '0; bus2.i_id_ctrl = IDEX_CTRL_NOP;
        bus2.i_wb_reg_write = 0; bus2.i_wb_rd = '0; bus2.i_wb_value = '0;
        bus2.i_flush = 0; bus2.i_hold = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst valid", 64'(bus.o_idex_valid), 64'(0));
        chk("rst pc",    bus.o_idex_pc, 64'(0));
        chk("rst ctrl",  64'(bus.o_idex_ctrl), 64'(0));
        chk("rst cnt",   64'(bus.o_stall_count), 64'(0));
        chk("rst stall", 64'(bus.o_stall), 64'(0));
        chk("rst cnt2",  64'(bus2.o_stall_count), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec($sformatf("v%0d", i), vecs[i]);
        end

        // async reset between edges while EX holds a valid load
        #1 rst = 1'b1;
        #1;
        chk("arst valid", 64'(bus.o_idex_valid), 64'(0));
        chk("arst pc",    bus.o_idex_pc, 64'(0));
        chk("arst rd",    64'(bus.o_idex_rd), 64'(0));
        chk("arst rs1v",  bus.o_idex_rs1_value, 64'(0));
        chk("arst ctrl",  64'(bus.o_idex_ctrl), 64'(0));
        chk("arst cnt",   64'(bus.o_stall_count), 64'(0));
        #1 rst = 1'b0;
        m_valid = 1'b0; m_pc = '0; m_imm = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = IDEX_CTRL_NOP;
        // first edge after release performs a normal load
        apply_vec("post_rst", mk(1, 'h300, 5, 1, 6, 1, 7, 'h33, 'h44, c_add, 0, 0, 0, 0, 0, 0, K_LOAD, 'h33, 'h44, 0));

        // saturation on a 2-bit counter: five load-use bubbles
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus2.i_id_valid = 1; bus2.i_id_rs1 = 5'd1; bus2.i_id_uses_rs1 = 1; bus2.i_id_rd = 5'd5;
            bus2.i_id_ctrl = c_ld;
            @(posedge clk);
            @(negedge clk);
            bus2.i_id_rs1 = 5'd5; bus2.i_id_rd = 5'd6; bus2.i_id_ctrl = c_add;
            #1;
            chk($sformatf("sat%0d stall", k), 64'(bus2.o_stall), 64'(1));
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d valid", k), 64'(bus2.o_idex_valid), 64'(0));
            chk($sformatf("sat%0d cnt", k), 64'(bus2.o_stall_count), 64'((k > 3) ? 3 : k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_register.md
# id_ex_register

ID/EX pipeline register for the 5-stage RV64 core. Sits between decode and execute and produces the `idex_*` operand, register and control fields that the EX-stage forwarding unit consumes. It also detects load-use hazards, inserts one-cycle bubbles, applies branch flushes, and provides write-through bypass for same-cycle writeback.

## Interface
Parameters:
- XLEN, 64, datapath width
- CNT_W, 32, width of the stall performance counter

Ports:
- i_clk  in  1  clock, all state rises on posedge
- i_rst  in  1  reset, asynchronous, active-high
- i_id_valid  in  1  decode stage holds a real instruction
- i_id_pc  in  XLEN  PC of decoded instruction
- i_id_rs1, i_id_rs2, i_id_rd  in  5 each  register indices
- i_id_uses_rs1, i_id_uses_rs2  in  1 each  instruction reads rs1/rs2
- i_id_rs1_value, i_id_rs2_value  in  XLEN each  register-file read data
- i_id_imm  in  XLEN  sign-extended immediate
- i_id_ctrl  in  idex_ctrl_t  decoded control bundle
- i_wb_reg_write  in  1  writeback is writing the register file this cycle
- i_wb_rd  in  5  writeback destination register
- i_wb_value  in  XLEN  writeback data
- i_flush  in  1  branch/jump taken in EX; squash the ID instruction
- i_hold  in  1  downstream (memory) stall; freeze this register
- o_idex_valid  out  1  EX holds a real instruction
- o_idex_pc, o_idex_imm  out  XLEN each
- o_idex_rs1, o_idex_rs2, o_idex_rd  out  5 each
- o_idex_rs1_value, o_idex_rs2_value  out  XLEN each
- o_idex_ctrl  out  idex_ctrl_t
- o_stall  out  1  hold PC and IF/ID this cycle
- o_stall_count  out  CNT_W  load-use bubbles inserted since reset

## Operation
- **Load-use detection (combinational).** `lu` = o_idex_valid & o_idex_ctrl.mem_to_reg & i_id_valid & (o_idex_rd != 0) & ((i_id_uses_rs1 & i_id_rs1 == o_idex_rd) | (i_id_uses_rs2 & i_id_rs2 == o_idex_rd)).
- **Stall output.** o_stall = (lu | i_hold) & ~i_flush.
- **Write-through bypass.** If i_wb_reg_write, i_wb_rd != 0 and i_wb_rd equals rs1 (or rs2), capture i_wb_value in place of the register-file data.
- **x0 handling.** An index of 0 always captures value 0, regardless of the bypass or the register-file data.
- **Per-edge update, strict priority:**
  1. i_rst: all outputs and state go to 0.
  2. i_flush: bubble. valid=0, ctrl=0, rd=0; other fields don't-care and held at 0.
  3. i_hold: all fields keep their value.
  4. lu: bubble as in (2); o_stall_count increments.
  5. Otherwise: load all ID fields; valid = i_id_valid.
- **Invalid ID instruction.** When i_id_valid=0 the register loads a bubble: ctrl forced to 0 and rd forced to 0.
- **Counter.** o_stall_count saturates at 2^CNT_W−1 and never wraps. It increments only on case (4).
- **Flush and load-use together.** The flush wins. No bubble is counted, and o_stall=0 so fetch redirects.

## Timing
- Every output except o_stall is registered, so latency from ID to EX is 1 cycle.
- o_stall is combinational from the current register contents and the ID inputs, and is valid in the same cycle.
- A load-use hazard always costs exactly one bubble. On the next cycle the load is in MEM, lu is 0, and the forwarding unit supplies the data from MEM/WB.
- Asynchronous reset: outputs are 0 immediately on i_rst assertion, mid-instruction included. On the first edge after deassertion the block performs a normal load.
- Sustained i_hold freezes the contents indefinitely. lu stays evaluated but is not acted on or counted while held.

## Structure
- Shared package `pipeline_pkg` holds:
  - `idex_ctrl_t` packed struct: alu_op[3:0], alu_src, mem_to_reg, mem_write, reg_write, branch, jump, funct3[2:0].
  - Constant `REG_ZERO = 5'd0`.
  - Constant `IDEX_CTRL_NOP`, all zeros.
- One sub-module, `load_use_detect`, is combinational and computes `lu`. It is reused by the hazard verification bench.
- The bypass muxes and the register stay in the top module.

## Test plan
- **Plain load.** ID add x3,x1,x2 with pc=0x100, rs1_value=5 → next cycle o_idex_valid=1, pc=0x100, rs1_value=5, o_stall=0.
- **Load-use stall.** EX holds `ld x5` (mem_to_reg=1). ID uses rs1=x5 → o_stall=1 this cycle; next cycle valid=0, ctrl=0, o_stall_count=1; the following cycle the instruction loads with o_stall=0.
- **No false stall on x0.** Load to x0 in EX and ID reads x0 → o_stall=0 and no bubble is inserted.
- **Write-through.** i_wb_reg_write=1, i_wb_rd=7, i_wb_value=0xDEAD; ID rs2=7 with stale register-file value 0x1 → o_idex_rs2_value=0xDEAD.
- **Flush overrides stall.** i_flush=1 while lu=1 → o_stall=0; next cycle valid=0 and o_stall_count unchanged. Then i_hold=1 for 3 cycles → all outputs frozen.
- **Async reset and saturation.** i_rst pulses between edges while valid=1 → all outputs read 0 before the next edge. Separately, with CNT_W=2, drive 5 load-use bubbles → o_stall_count stays at 3.
